// File: rtl/dds_channel_scheduler.sv
// Time-shares one cordicsine core across NCH DDS channels: each tick walks the enabled channels in
// ascending order, advancing the phase, issuing the angle and capturing the core result (or timing out).
module dds_channel_scheduler #(
  parameter int                 NCH     = 4,
  parameter logic signed [15:0] PI_VAL  = 16'sd12868,
  parameter int                 TIMEOUT = 64,
  localparam int                CW      = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              cfg_we,
  input  logic [CW-1:0]     cfg_ch,
  input  logic [15:0]       cfg_inc,
  input  logic              cfg_en,
  input  logic              cfg_clr,
  output logic              core_update,
  output logic [15:0]       core_angle,
  input  logic              core_ready,
  input  logic [15:0]       core_q,
  output logic [NCH*16-1:0] ch_q,
  output logic [NCH-1:0]    ch_valid,
  output logic              round_done,
  output logic              busy,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int               TW   = $clog2(TIMEOUT + 1);
  localparam logic signed [16:0] PI17 = {PI_VAL[15], PI_VAL};

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [15:0]     phase_q [NCH];
  logic [15:0]     inc_q   [NCH];
  logic [15:0]     samp_q  [NCH];
  logic [NCH-1:0]  en_q, pend_q, ch_valid_q;
  logic [CW-1:0]   cur_q;
  logic [15:0]     angle_q;
  logic [TW-1:0]   tmo_cnt_q;
  logic            tmo_err_q;

  logic [CW-1:0]   sel_idx;
  logic            sel_found;
  logic            tmo_hit, wait_exit, rest_empty;

  function automatic logic [15:0] wrap_add(input logic [15:0] p, input logic [15:0] d);
    logic signed [16:0] s;
    s = $signed({p[15], p}) + $signed({d[15], d});
    if (s > PI17)       s = s - (PI17 + PI17);
    else if (s < -PI17) s = s + (PI17 + PI17);
    return s[15:0];
  endfunction

  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_idx   = CW'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign tmo_hit    = (tmo_cnt_q == TW'(TIMEOUT - 1));
  assign wait_exit  = core_ready || tmo_hit;
  // Skipping the empty trailing SEL keeps a round at n*(2+L)+1 cycles.
  assign rest_empty = ((pend_q & ~(NCH'(1) << cur_q)) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (tick) state_d = (en_q == '0) ? S_DONE : S_SEL;
      S_SEL:   state_d = sel_found ? S_ISSUE : S_DONE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (wait_exit) state_d = rest_empty ? S_DONE : S_SEL;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    core_update = (state_q == S_ISSUE);
    round_done  = (state_q == S_DONE);
    overrun     = tick && (state_q != S_IDLE);
    core_angle  = angle_q;
    ch_valid    = ch_valid_q;
    timeout_err = tmo_err_q;
    for (int i = 0; i < NCH; i++) ch_q[16*i +: 16] = samp_q[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        phase_q[i] <= '0;
        inc_q[i]   <= '0;
        samp_q[i]  <= '0;
      end
      en_q       <= '0;
      pend_q     <= '0;
      ch_valid_q <= '0;
      cur_q      <= '0;
      angle_q    <= '0;
      tmo_cnt_q  <= '0;
      tmo_err_q  <= 1'b0;
    end else begin
      ch_valid_q <= '0;
      tmo_err_q  <= 1'b0;
      if (state_q == S_IDLE && tick) pend_q <= en_q;
      if (state_q == S_SEL && sel_found) begin
        cur_q   <= sel_idx;
        angle_q <= wrap_add(phase_q[sel_idx], inc_q[sel_idx]);
      end
      if (state_q == S_ISSUE) tmo_cnt_q <= '0;
      if (state_q == S_WAIT) begin
        tmo_cnt_q <= tmo_cnt_q + TW'(1);
        if (wait_exit) pend_q[cur_q] <= 1'b0;
        if (!core_ready && tmo_hit) tmo_err_q <= 1'b1;
      end
      // Config write follows the ISSUE phase update so a same-cycle clear wins.
      for (int i = 0; i < NCH; i++) begin
        if (state_q == S_ISSUE && cur_q == CW'(i)) phase_q[i] <= angle_q;
        if (state_q == S_WAIT && core_ready && cur_q == CW'(i)) begin
          samp_q[i]     <= core_q;
          ch_valid_q[i] <= 1'b1;
        end
        if (cfg_we && cfg_ch == CW'(i)) begin
          inc_q[i] <= cfg_inc;
          en_q[i]  <= cfg_en;
          if (cfg_clr) phase_q[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dds_channel_scheduler.sv
// Scoreboard bench for dds_channel_scheduler: a round-level reference model queues expected events at
// each tick; a negedge monitor pops and compares core issues, captures, timeouts and round completions.
module tb_dds_channel_scheduler;
  localparam int NCH = 4;
  localparam int CW = 2;
  localparam int TIMEOUT = 64;
  localparam int PI = 12868;

  logic clk = 1'b0, reset = 1'b1, tick = 1'b0;
  logic cfg_we = 1'b0, cfg_en = 1'b0, cfg_clr = 1'b0;
  logic [CW-1:0] cfg_ch = '0;
  logic [15:0] cfg_inc = '0;
  logic core_update, core_ready = 1'b0;
  logic [15:0] core_angle, core_q = '0;
  logic [NCH*16-1:0] ch_q;
  logic [NCH-1:0] ch_valid;
  logic round_done, busy, overrun, timeout_err;

  dds_channel_scheduler #(.NCH(NCH), .PI_VAL(16'sd12868), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .tick(tick), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc),
    .cfg_en(cfg_en), .cfg_clr(cfg_clr), .core_update(core_update), .core_angle(core_angle),
    .core_ready(core_ready), .core_q(core_q), .ch_q(ch_q), .ch_valid(ch_valid),
    .round_done(round_done), .busy(busy), .overrun(overrun), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  typedef enum int {E_UPD, E_VALID, E_TMO, E_DONE} kind_t;
  typedef struct { kind_t kind; int ch; logic [15:0] val; int dt; } exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0;
  int cyc = 0, tick_cyc = 0, last_upd = 0, busy_cnt = 0, rounds_done = 0, upd_cnt = 0;
  logic [15:0] last_angle;
  int core_lat = 1;
  bit core_never = 1'b0;

  int m_phase [NCH], m_inc [NCH];
  bit m_en [NCH];
  logic [15:0] m_chq [NCH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] corefn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  // Reference model: one whole round worth of expected events from the channel tables.
  task automatic model_round();
    int n = 0, s;
    for (int c = 0; c < NCH; c++) begin
      if (!m_en[c]) continue;
      s = m_phase[c] + m_inc[c];
      if (s > PI) s -= 2 * PI;
      else if (s < -PI) s += 2 * PI;
      m_phase[c] = s;
      sb.push_back('{E_UPD, c, 16'(s), 0});
      if (core_never) sb.push_back('{E_TMO, c, 16'h0, TIMEOUT + 1});
      else begin
        sb.push_back('{E_VALID, c, corefn(16'(s)), core_lat + 1});
        m_chq[c] = corefn(16'(s));
      end
      n++;
    end
    sb.push_back('{E_DONE, 0, 16'h0, (n == 0) ? 1 : n * (2 + (core_never ? TIMEOUT : core_lat)) + 1});
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_phase[c] = 0; m_inc[c] = 0; m_en[c] = 1'b0; m_chq[c] = '0;
    end
  endtask

  // Core stand-in: result-valid L cycles after the update pulse.
  initial forever begin
    @(negedge clk);
    if (core_update && !reset && !core_never) begin
      automatic logic [15:0] a = core_angle;
      repeat (core_lat) @(posedge clk);
      #1 core_ready = 1'b1; core_q = corefn(a);
      @(posedge clk);
      #1 core_ready = 1'b0; core_q = $urandom();
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      busy_cnt = 0;
    end else begin
      if (core_update) begin
        upd_cnt++;
        last_upd = cyc;
        last_angle = core_angle;
        if (sb.size() == 0) check("unexpected_update", 1, 0);
        else begin
          e = sb.pop_front();
          check("event_kind_upd", e.kind, E_UPD);
          check("core_angle", core_angle, e.val);
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (ch_valid[c]) begin
          if (sb.size() == 0) check("unexpected_ch_valid", 1, 0);
          else begin
            e = sb.pop_front();
            check("event_kind_valid", e.kind, E_VALID);
            check("valid_channel", c, e.ch);
            check("ch_q_capture", ch_q[16*c +: 16], e.val);
            check("valid_latency", cyc - last_upd, e.dt);
          end
        end
      end
      if (timeout_err) begin
        if (sb.size() == 0) check("unexpected_timeout", 1, 0);
        else begin
          e = sb.pop_front();
          check("event_kind_tmo", e.kind, E_TMO);
          check("timeout_latency", cyc - last_upd, e.dt);
        end
      end
      if (busy) busy_cnt++;
      if (round_done) begin
        if (sb.size() == 0) check("unexpected_round_done", 1, 0);
        else begin
          e = sb.pop_front();
          check("event_kind_done", e.kind, E_DONE);
          check("round_length", cyc - tick_cyc, e.dt);
          check("busy_cycles", busy_cnt, e.dt);
        end
        busy_cnt = 0;
        rounds_done++;
      end
    end
  end

  task automatic cfg_write(input int ch, input int inc, input bit en, input bit clr);
    @(posedge clk);
    #1 cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_inc = 16'(inc); cfg_en = en; cfg_clr = clr;
    m_inc[ch] = inc; m_en[ch] = en;
    if (clr) m_phase[ch] = 0;
    @(posedge clk);
    #1 cfg_we = 1'b0; cfg_clr = 1'b0;
  endtask

  task automatic do_tick();
    @(posedge clk);
    #1 tick = 1'b1;
    tick_cyc = cyc;
    model_round();
    @(negedge clk);
    check("no_overrun_when_idle", overrun, 0);
    @(posedge clk);
    #1 tick = 1'b0;
  endtask

  task automatic wait_round(input int target);
    int k = 0;
    while (rounds_done < target && k < 2000) begin
      @(posedge clk);
      k++;
    end
    if (rounds_done < target) check("round_completion_budget", rounds_done, target);
    repeat (2) @(posedge clk);
  endtask

  task automatic round(input int lat, input bit never);
    int tgt;
    core_lat = lat; core_never = never;
    tgt = rounds_done + 1;
    do_tick();
    wait_round(tgt);
    core_never = 1'b0;
  endtask

  initial begin
    int k, tgt;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_core_update", core_update, 0);
    check("rst_core_angle", core_angle, 0);
    check("rst_ch_q", ch_q, 0);
    check("rst_ch_valid", ch_valid, 0);
    check("rst_round_done", round_done, 0);
    check("rst_timeout_err", timeout_err, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    cfg_write(0, 100, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) round(4, 1'b0);
    check("angle_third_round", last_angle, 16'd300);

    cfg_write(0, 100, 1'b0, 1'b0);
    cfg_write(1, 12800, 1'b1, 1'b0);
    round(1, 1'b0);
    cfg_write(1, 200, 1'b1, 1'b0);
    round(1, 1'b0);
    check("wrap_positive", last_angle, 16'hCE40);
    cfg_write(1, -12800, 1'b1, 1'b1);
    round(2, 1'b0);
    cfg_write(1, -200, 1'b1, 1'b0);
    round(2, 1'b0);
    check("wrap_negative", last_angle, 16'd12736);

    for (int c = 0; c < NCH; c++) cfg_write(c, 1000 * (c + 1), 1'b1, 1'b0);
    round(2, 1'b0);

    for (int c = 1; c < NCH; c++) cfg_write(c, 0, 1'b0, 1'b0);
    core_lat = 4;
    tgt = rounds_done + 1;
    do_tick();
    @(posedge clk);
    #1 tick = 1'b1;
    @(negedge clk);
    check("overrun_pulse", overrun, 1);
    @(posedge clk);
    #1 tick = 1'b0;
    wait_round(tgt);
    repeat (10) @(posedge clk);
    check("no_second_round", rounds_done, tgt);

    // Inc write plus clear landing in ch0's ISSUE cycle.
    cfg_write(0, 500, 1'b1, 1'b0);
    core_lat = 3;
    tgt = rounds_done + 1;
    do_tick();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!core_update && k < 50);
    cfg_we = 1'b1; cfg_ch = '0; cfg_inc = 16'd1000; cfg_en = 1'b1; cfg_clr = 1'b1;
    m_inc[0] = 1000; m_phase[0] = 0;
    @(posedge clk);
    #1 cfg_we = 1'b0; cfg_clr = 1'b0;
    wait_round(tgt);
    round(3, 1'b0);
    check("issue_cycle_clear", last_angle, 16'd1000);

    cfg_write(0, 7, 1'b0, 1'b0);
    cfg_write(1, 300, 1'b1, 1'b0);
    cfg_write(2, -300, 1'b1, 1'b0);
    round(1, 1'b1);
    check("timeout_second_issued", last_angle, m_phase[2]);

    for (int c = 0; c < NCH; c++) cfg_write(c, m_inc[c], 1'b0, 1'b0);
    round(1, 1'b0);

    for (int r = 0; r < 20; r++) begin
      int nw = $urandom_range(3, 1);
      for (int w = 0; w < nw; w++)
        cfg_write($urandom_range(NCH - 1), int'($urandom_range(2 * PI)) - PI,
                  ($urandom_range(3) != 0), ($urandom_range(3) == 0));
      round($urandom_range(6, 1), 1'b0);
    end

    for (int c = 0; c < NCH; c++)
      check("final_ch_q", ch_q[16*c +: 16], m_chq[c]);
    check("scoreboard_drained", sb.size(), 0);

    for (int c = 0; c < NCH; c++) cfg_write(c, 50 * (c + 1), 1'b1, 1'b0);
    core_lat = 3;
    k = upd_cnt + 3;
    do_tick();
    tgt = 0;
    while (upd_cnt < k && tgt < 200) begin
      @(posedge clk);
      tgt++;
    end
    check("reached_ch2_issue", upd_cnt, k);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("midrst_core_update", core_update, 0);
    check("midrst_busy", busy, 0);
    check("midrst_core_angle", core_angle, 0);
    check("midrst_ch_q", ch_q, 0);
    check("midrst_ch_valid", ch_valid, 0);
    model_reset();
    repeat (6) @(posedge clk);
    #1 reset = 1'b0;
    cfg_write(0, 321, 1'b1, 1'b0);
    round(2, 1'b0);
    check("post_reset_angle", last_angle, 16'd321);
    check("post_reset_ch_q", ch_q[15:0], corefn(16'd321));
    check("post_reset_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dds_channel_scheduler.md
Name: dds_channel_scheduler

Overview:
Time-shares one cordicsine core among NCH independent DDS channels. Each channel has its own phase accumulator and frequency increment. On each sample tick the block walks the enabled channels in ascending index order. For each channel it advances the phase, issues the angle to the core, waits for the core's ready, and stores the result into that channel's output register. It sits between the register/config interface and the shared cordicsine instance, replacing a per-channel ddstop-style wrapper.

Parameters:
NCH, 4, number of channels (2..8); channel index width CW = clog2(NCH)
PI_VAL, 16'sd12868, pi in the angle format (signed Q3.12); must match the cordicsine angle format
TIMEOUT, 64, max cycles to wait for core_ready before abandoning a channel

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  sample strobe; starts one round when idle
cfg_we  in  1  config write strobe
cfg_ch  in  CW  channel addressed by the write
cfg_inc  in  16  signed phase increment to load
cfg_en  in  1  channel enable value to load
cfg_clr  in  1  when 1 with cfg_we: channel phase is cleared to 0
core_update  out  1  one-cycle start pulse to cordicsine
core_angle  out  16  angle presented to cordicsine
core_ready  in  1  cordicsine result-valid
core_q  in  16  cordicsine result
ch_q  out  NCH*16  per-channel last sample; channel i occupies bits [16i+15:16i]
ch_valid  out  NCH  one-cycle pulse per channel when ch_q[i] updates
round_done  out  1  one-cycle pulse when a round finishes
busy  out  1  high from the cycle after the accepted tick through the DONE cycle
overrun  out  1  one-cycle pulse: tick arrived while busy
timeout_err  out  1  one-cycle pulse: a channel timed out

Behaviour:
- Reset (async): all phases, increments, enables, ch_q = 0; core_update, ch_valid, round_done, overrun, timeout_err = 0; busy = 0; core_angle = 0; FSM = IDLE.
- FSM states: IDLE, SEL, ISSUE, WAIT, DONE.
- IDLE, tick=1:
  - Snapshot the enable mask.
  - Mask all zero: go directly to DONE (round_done with no core activity).
  - Otherwise: go to SEL.
- SEL: pick the lowest enabled, not-yet-served index in the snapshot. If one exists, go to ISSUE; otherwise go to DONE.
- ISSUE (exactly 1 cycle):
  - phase[ch] <= wrap(phase[ch] + inc[ch]).
  - core_angle = the new wrapped phase, registered and held stable until WAIT exits.
  - core_update = 1 for this cycle only. Go to WAIT.
- wrap():
  - 17-bit signed sum s.
  - If s > PI_VAL: s - 2*PI_VAL.
  - Else if s < -PI_VAL: s + 2*PI_VAL.
  - Else s. Result truncated to 16 bits.
  - Increments must satisfy |inc| <= PI_VAL, so a single correction suffices.
- WAIT:
  - core_ready is ignored in the ISSUE cycle and sampled from the first WAIT cycle.
  - core_ready=1: ch_q[ch] <= core_q; ch_valid[ch] pulses the next cycle; mark channel served; go to SEL.
  - TIMEOUT cycles elapse without ready: ch_q unchanged; timeout_err pulses; channel marked served; go to SEL.
- DONE: round_done = 1 for one cycle; go to IDLE.
- Per-channel cost: 1 (SEL) + 1 (ISSUE) + L cycles, where L = update-to-ready latency, L >= 1.
- tick while busy: ignored; overrun pulses that cycle. tick in the DONE cycle also counts as overrun.
- Config writes are accepted in any state, one channel per cycle:
  - inc/en written immediately.
  - A write to the channel in its ISSUE cycle: the old inc is used this round; the new inc applies from the next round.
  - cfg_clr during ISSUE of that channel: clear wins, phase = 0.
  - en changes affect only the next round, because the mask is snapshotted at tick.
- Phases of disabled channels hold their value.
- Reset mid-round: immediate return to reset state. core_update drops asynchronously and no partial capture occurs.

Test Plan:
- Reset, inc[0]=100, en[0]=1, tick ×3 with a core model L=4 -> core_angle 100, 200, 300; ch_valid[0] pulses 3 times; ch_q[0]=core_q each time; round_done 7 cycles after each tick.
- Wrap: phase[1]=12800 (via increments), inc[1]=200 -> issued angle -12736. Negative case: phase -12800, inc -200 -> 12736.
- All 4 enabled, core L=2 -> core_update order ch0,ch1,ch2,ch3; 4 single ch_valid pulses; busy for 17 cycles.
- tick asserted 3 cycles after the start of a round -> overrun=1 for that cycle; round completes normally; no second round starts.
- Core model never asserts ready, TIMEOUT=64 -> timeout_err pulse 64 cycles into WAIT; ch_q unchanged; next channel still issued.
- Reset asserted during WAIT of ch2 -> all outputs 0 in the same cycle; after release, tick starts a fresh round at ch0 with phase = inc.
